// File: rtl/mm_sequencer.sv
// Sequencer for the N x N matrix product C = A*B: walks i/j/k, issues operand
// reads, drives the MAC enables and writes each C element via a ready handshake.
module mm_sequencer #(
  parameter int N      = 4,
  parameter int AW     = 8,
  parameter int A_BASE = 0,
  parameter int B_BASE = 16,
  parameter int C_BASE = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          abort,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr_a,
  output logic [AW-1:0] rd_addr_b,
  output logic          mac_en,
  output logic          mac_first,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  input  logic          wr_ready,
  output logic          busy,
  output logic          done
);

  localparam int CW = ($clog2(N) < 1) ? 1 : $clog2(N);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] i, j, k;
  logic [CW-1:0] i_n, j_n, k_n;

  logic          rd_en_n, mac_en_n, mac_first_n, wr_en_n, busy_n, done_n;
  logic [AW-1:0] rd_addr_a_n, rd_addr_b_n, wr_addr_n;
  logic          last_elem;

  assign last_elem = (i == CW'(N - 1)) && (j == CW'(N - 1));

  always_comb begin
    state_n = state;
    i_n     = i;
    j_n     = j;
    k_n     = k;
    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          state_n = S_LOAD;
          i_n     = '0;
          j_n     = '0;
          k_n     = '0;
        end
      end
      S_LOAD: begin
        if (k == CW'(N - 1)) begin
          k_n     = '0;
          state_n = S_DRAIN;
        end else begin
          k_n = k + CW'(1);
        end
      end
      S_DRAIN: state_n = S_WRITE;
      S_WRITE: begin
        if (wr_ready) begin
          if (last_elem) begin
            state_n = S_DONE;
          end else if (j != CW'(N - 1)) begin
            j_n     = j + CW'(1);
            state_n = S_LOAD;
          end else begin
            j_n     = '0;
            i_n     = i + CW'(1);
            state_n = S_LOAD;
          end
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        i_n     = '0;
        j_n     = '0;
      end
      default: state_n = S_IDLE;
    endcase
    // Abort overrides every transition out of a busy state, including a
    // write being accepted in the same cycle.
    if (abort && state != S_IDLE) begin
      state_n = S_IDLE;
      i_n     = '0;
      j_n     = '0;
      k_n     = '0;
    end
  end

  // Outputs are registered from the next-state view so they line up with state.
  always_comb begin
    rd_en_n     = (state_n == S_LOAD);
    wr_en_n     = (state_n == S_WRITE);
    busy_n      = (state_n != S_IDLE);
    done_n      = (state_n == S_DONE);
    mac_en_n    = rd_en && (state_n != S_IDLE);
    mac_first_n = mac_en_n && (k == '0);
    rd_addr_a_n = '0;
    rd_addr_b_n = '0;
    wr_addr_n   = '0;
    if (rd_en_n) begin
      rd_addr_a_n = AW'(A_BASE) + AW'(i_n) * AW'(N) + AW'(k_n);
      rd_addr_b_n = AW'(B_BASE) + AW'(k_n) * AW'(N) + AW'(j_n);
    end
    if (wr_en_n) begin
      wr_addr_n = AW'(C_BASE) + AW'(i_n) * AW'(N) + AW'(j_n);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      i         <= '0;
      j         <= '0;
      k         <= '0;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      mac_en    <= 1'b0;
      mac_first <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      i         <= i_n;
      j         <= j_n;
      k         <= k_n;
      rd_en     <= rd_en_n;
      rd_addr_a <= rd_addr_a_n;
      rd_addr_b <= rd_addr_b_n;
      mac_en    <= mac_en_n;
      mac_first <= mac_first_n;
      wr_en     <= wr_en_n;
      wr_addr   <= wr_addr_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

endmodule

// File: tb/tb_mm_sequencer.sv
// Bench for mm_sequencer: element/phase model compared every cycle, plus
// directed latency, stall, abort and reset scenarios with literal expectations.
module tb_mm_sequencer;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int AB = 0;
  localparam int BB = 16;
  localparam int CB = 32;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic          abort;
  logic          rd_en;
  logic [AW-1:0] rd_addr_a;
  logic [AW-1:0] rd_addr_b;
  logic          mac_en;
  logic          mac_first;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          wr_ready;
  logic          busy;
  logic          done;

  mm_sequencer #(
    .N      (N),
    .AW     (AW),
    .A_BASE (AB),
    .B_BASE (BB),
    .C_BASE (CB)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .abort     (abort),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .mac_en    (mac_en),
    .mac_first (mac_first),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_ready  (wr_ready),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit chk_en   = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0d expected=%0d", name, $time, act, exp);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Model: progress is element index e (C address offset = i*N+j) and phase p
  // within the element: p<N reading k=p, p==N drain, p==N+1 write.
  bit m_act  = 0;
  bit m_done = 0;
  int m_e    = 0;
  int m_p    = 0;
  bit was_rd, was_k0;
  logic e_mac   = 0;
  logic e_first = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_act = 0; m_done = 0; m_e = 0; m_p = 0; e_mac = 0; e_first = 0;
    end else begin
      was_rd = m_act && (m_p < N);
      was_k0 = (m_p == 0);
      if (m_done) m_done = 0;
      else if (!m_act) begin
        if (start && !abort) begin m_act = 1; m_e = 0; m_p = 0; end
      end
      else if (abort) m_act = 0;
      else if (m_p < N + 1) m_p++;
      else if (wr_ready) begin
        if (m_e == N * N - 1) begin m_act = 0; m_done = 1; end
        else begin m_e++; m_p = 0; end
      end
      e_mac   = was_rd && m_act;
      e_first = e_mac && was_k0;
    end
  end

  logic       e_rd, e_wr, e_busy, e_done;
  logic [7:0] e_ra, e_rb, e_wa;
  assign e_rd   = m_act && (m_p < N);
  assign e_wr   = m_act && (m_p == N + 1);
  assign e_busy = m_act || m_done;
  assign e_done = m_done;
  assign e_ra   = 8'(AB + (m_e / N) * N + m_p);
  assign e_rb   = 8'(BB + m_p * N + (m_e % N));
  assign e_wa   = 8'(CB + m_e);

  always @(negedge clk) begin
    if (reset_n && chk_en) begin
      chk("rd_en", rd_en, e_rd);
      chk("mac_en", mac_en, e_mac);
      chk("mac_first", mac_first, e_first);
      chk("wr_en", wr_en, e_wr);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      if (e_rd) begin
        chk("rd_addr_a", rd_addr_a, e_ra);
        chk("rd_addr_b", rd_addr_b, e_rb);
      end
      if (e_wr) chk("wr_addr", wr_addr, e_wa);
    end
  end

  // Observation logs for the directed scenarios.
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] wq[$];
  int done_cnt = 0, mac_cnt = 0, first_cnt = 0, w38_cnt = 0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (rd_en) begin qa.push_back(rd_addr_a); qb.push_back(rd_addr_b); end
      if (wr_en && wr_ready) wq.push_back(wr_addr);
      if (wr_en && wr_addr == 8'd38) w38_cnt++;
      if (done) done_cnt++;
      if (mac_en) mac_cnt++;
      if (mac_first) first_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    qa.delete(); qb.delete(); wq.delete();
    mac_cnt = 0; first_cnt = 0; w38_cnt = 0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_rd_addr_a"}, rd_addr_a, 0);
    chk({tag, "_rd_addr_b"}, rd_addr_b, 0);
    chk({tag, "_mac_en"}, mac_en, 0);
    chk({tag, "_mac_first"}, mac_first, 0);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic kick(output int t0);
    start = 1; t0 = cyc; tick(); start = 0;
  endtask

  task automatic wait_done(input int budget, output int at);
    bit seen;
    seen = 0; at = -1;
    for (int n = 0; n < budget && !seen; n++) begin
      if (done) begin seen = 1; at = cyc; end
      else tick();
    end
    if (!seen) chk("wait_done_timeout", 0, 1);
  endtask

  int  t0, at, d0;
  bit  stalled, hit;

  initial begin
    reset_n = 0; start = 0; abort = 0; wr_ready = 1;
    repeat (2) tick();
    check_zero("reset");
    reset_n = 1; chk_en = 1;
    tick();

    // Full product with wr_ready held high.
    clear_logs(); d0 = done_cnt;
    kick(t0);
    wait_done(200, at);
    chk("latency_97", at - t0, 97);
    tick();
    chk("done_once", done_cnt - d0, 1);
    chk("rd_count", qa.size(), 64);
    for (int n = 0; n < 4; n++) begin
      chk("first_rd_a", qa[n], n);
      chk("first_rd_b", qb[n], 16 + 4 * n);
    end
    chk("wr_count", wq.size(), 16);
    for (int n = 0; n < 16; n++) chk("wr_order", wq[n], 32 + n);
    chk("mac_cycles", mac_cnt, 64);
    chk("mac_first_cycles", first_cnt, 16);

    // Stall the write of C[1][2] for 5 cycles.
    clear_logs(); stalled = 0; at = -1;
    kick(t0);
    for (int n = 0; n < 300 && at < 0; n++) begin
      if (done) at = cyc;
      else begin
        if (!stalled && wr_en && wr_addr == 8'd38) begin
          wr_ready = 0; repeat (5) tick(); wr_ready = 1; stalled = 1;
        end else tick();
      end
    end
    chk("stall_latency_102", at - t0, 102);
    chk("stall_hold_38", w38_cnt, 6);
    tick();
    chk("stall_wr_count", wq.size(), 16);

    // Abort at k=2 of C[2][0].
    clear_logs(); d0 = done_cnt; hit = 0;
    kick(t0);
    for (int n = 0; n < 200 && !hit; n++) begin
      if (rd_en && rd_addr_a == 8'd10 && rd_addr_b == 8'd24) hit = 1;
      else tick();
    end
    chk("abort_point_found", hit, 1);
    abort = 1; tick(); abort = 0;
    check_zero("abort");
    chk("abort_writes", wq.size(), 8);
    repeat (3) tick();
    chk("abort_no_done", done_cnt - d0, 0);

    // Restart after abort, pulse start mid-run, and hold start in the DONE cycle.
    clear_logs();
    kick(t0);
    repeat (10) tick();
    start = 1; tick(); start = 0;
    wait_done(200, at);
    chk("restart_latency_97", at - t0, 97);
    start = 1; tick(); start = 0;
    chk("start_in_done_ignored", busy, 0);
    chk("restart_rd_a", qa[0], 0);
    chk("restart_rd_b", qb[0], 16);
    chk("restart_wr0", wq[0], 32);

    // Start together with abort in IDLE.
    start = 1; abort = 1; tick(); start = 0; abort = 0;
    chk("start_abort_idle_busy", busy, 0);
    tick();
    chk("start_abort_idle_rd", rd_en, 0);

    // Asynchronous reset during the write of C[3][3].
    clear_logs(); d0 = done_cnt; hit = 0;
    kick(t0);
    for (int n = 0; n < 200 && !hit; n++) begin
      if (wr_en && wr_addr == 8'd47) begin hit = 1; wr_ready = 0; end
      else tick();
    end
    chk("last_write_found", hit, 1);
    tick();
    #1 reset_n = 0;
    #1 check_zero("async_reset");
    wr_ready = 1;
    repeat (2) tick();
    reset_n = 1;
    repeat (2) tick();
    chk("reset_no_done", done_cnt - d0, 0);
    chk("reset_wr_count", wq.size(), 15);

    // Randomized traffic checked against the model every cycle.
    for (int n = 0; n < 4000; n++) begin
      start    = ($urandom_range(0, 7) == 0);
      abort    = ($urandom_range(0, 299) == 0);
      wr_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    start = 0; abort = 0; wr_ready = 1;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mm_sequencer.md
Name: mm_sequencer

Overview:
- Top-level controller for the matrix multiplier. It sequences the N×N product C = A·B.
- Issues operand read addresses for A and B to the operand memory.
- Drives the multiply-accumulate datapath enables.
- Writes each finished C element to result memory through a ready/enable handshake.
- Replaces the free-running done-pulse address counting in the result path with an explicit, clocked, stall-aware schedule.

Parameters:
- N, 4, matrix dimension (N ≥ 2); counters i, j, k are max(1, clog2(N)) bits wide.
- AW, 8, address width; must hold C_BASE + N*N − 1.
- A_BASE, 0, base address of A (row-major).
- B_BASE, 16, base address of B (row-major).
- C_BASE, 32, base address of C (row-major).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a multiply; sampled only in IDLE.
- abort  in  1  synchronous cancel; return to IDLE.
- rd_en  out  1  operand read strobe; data is valid one cycle later.
- rd_addr_a  out  AW  A[i][k] address = A_BASE + i*N + k.
- rd_addr_b  out  AW  B[k][j] address = B_BASE + k*N + j.
- mac_en  out  1  accumulate the operand product this cycle (rd_en delayed 1 cycle).
- mac_first  out  1  with mac_en: accumulator loads the product instead of adding (k==0, delayed 1 cycle).
- wr_en  out  1  result write request.
- wr_addr  out  AW  C[i][j] address = C_BASE + i*N + j.
- wr_ready  in  1  result memory accepts the write when wr_en && wr_ready.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the final C element is accepted.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE; i=j=k=0.
  - All outputs 0, including addresses.
  - Reset mid-operation discards all progress; no done pulse.
- All outputs are registered.
- Address arithmetic is done at AW bits, truncated modulo 2^AW.
- IDLE:
  - start=1 → LOAD with i=j=k=0.
  - start=0 → remain in IDLE.
- LOAD (N cycles per element):
  - rd_en=1, with rd_addr_a/rd_addr_b for the current k.
  - k increments each cycle.
  - When k==N−1: k←0 and go to DRAIN.
- DRAIN (1 cycle):
  - rd_en=0.
  - The last mac_en of the element occurs this cycle.
  - Next state: WRITE.
- WRITE:
  - wr_en=1, wr_addr=C_BASE+i*N+j.
  - Hold wr_en and wr_addr stable until wr_ready=1 is sampled.
  - On acceptance:
    - If (i,j)==(N−1,N−1) → DONE.
    - Else if j<N−1 → j++, go to LOAD.
    - Else → j=0, i++, go to LOAD.
- DONE (1 cycle):
  - done=1, busy=1.
  - Next state: IDLE (i=j=0).
- mac_en/mac_first timing:
  - mac_en(t+1)=rd_en(t).
  - mac_first(t+1)=rd_en(t)&&(k(t)==0).
  - mac_first is never high without mac_en.
- Latency with wr_ready held at 1:
  - N+2 cycles per element.
  - N*N*(N+2)+1 cycles from the start cycle to the done pulse (97 cycles for N=4).
- Boundary conditions:
  - start while busy: ignored.
  - start and abort together in IDLE: abort wins; stay in IDLE.
  - abort in any non-IDLE state: next cycle IDLE, all outputs 0, no done, no write issued; an in-flight mac_en may be dropped.
  - abort in the same cycle as a WRITE acceptance: the write is accepted, then the block goes to IDLE.
  - wr_ready while not in WRITE: ignored.
  - wr_ready low indefinitely: remain in WRITE; no timeout.
  - start high in the DONE cycle: ignored; a new start must be sampled in IDLE.

Test Plan:
- Reset (reset_n=0 asserted mid-cycle), then released; start=1 for one cycle, wr_ready=1 → rd_addr_a sequence 0,1,2,3 and rd_addr_b 16,20,24,28 for C[0][0]; first wr_addr=32; done pulses exactly 97 cycles after start; 16 writes to addresses 32..47 in order.
- Pipelined MAC check → mac_en is high for exactly 4 consecutive cycles per element, one cycle after rd_en; mac_first is high only on the first of the 4.
- wr_ready=0 for 5 cycles during the write of C[1][2] (addr 38) → wr_en/wr_addr held at 38 for 6 cycles; no read issued; total latency +5.
- abort at k=2 of C[2][0] → IDLE next cycle, busy=0, no write to addr 40, no done; a subsequent start restarts at C[0][0].
- reset_n low during WRITE of C[3][3] → outputs 0 immediately (asynchronously); no done; start is ignored while busy and start+abort in IDLE stays IDLE.
